// File: rtl/core_pkg.sv
// Shared FSM state type, line geometry and byte-mask helper for the data-cache arbiter.
package core_pkg;

    localparam int LINE_OFFSET_BITS = 5;
    localparam int LINE_BYTES       = 1 << LINE_OFFSET_BITS;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_REQ,
        ST_WAIT,
        ST_RESOLVE
    } arb_state_e;

    // Enabled bytes of one 32-bit word, positioned at its word slot inside a line.
    function automatic logic [LINE_BYTES-1:0] word_byte_mask(input logic [3:0] be,
                                                             input logic [2:0] word_off);
        logic [LINE_BYTES-1:0] mask;
        mask = '0;
        mask[{word_off, 2'b00} +: 4] = be;
        return mask;
    endfunction

endpackage

// File: rtl/dcache_line_merge.sv
// Combinational merge of a 32-bit store word (with byte enables) into a cache line.
module dcache_line_merge import core_pkg::*; #(
    parameter int LINE_BITS = 256
) (
    input  logic [LINE_BITS-1:0] line,
    input  logic [31:0]          word,
    input  logic [3:0]           be,
    input  logic [2:0]           word_off,
    output logic [LINE_BITS-1:0] merged
);

    localparam int NBYTES = LINE_BITS / 8;

    logic [LINE_BYTES-1:0] mask;

    always_comb begin
        mask   = word_byte_mask(be, word_off);
        merged = line;
        for (int i = 0; i < NBYTES; i++) begin
            if (mask[i]) begin
                merged[8*i +: 8] = word[8*(i%4) +: 8];
            end
        end
    end

endmodule

// File: rtl/dcache_arbiter.sv
// Data-cache arbiter: load/store grant, in-flight load tracking and single-line miss refill.
// Defining DCACHE_ARB_PERF_EN adds wrapping 32-bit load-miss, store-miss and collision counters.
module dcache_arbiter import core_pkg::*; #(
    parameter int LOAD_LAT  = 2,
    parameter int LINE_BITS = 256
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   ld_valid,
    output logic                   ld_ready,
    input  logic [31:0]            ld_addr,
    output logic                   ld_resp_valid,
    output logic [31:0]            ld_resp_data,
    input  logic                   st_valid,
    output logic                   st_ready,
    input  logic [31:0]            st_addr,
    input  logic [31:0]            st_data,
    input  logic [3:0]             st_be,
    output logic                   raddr_valid,
    output logic [31:0]            raddr,
    input  logic [31:0]            rdata,
    output logic                   waddr_valid,
    output logic [31:0]            waddr,
    output logic [LINE_BITS-1:0]   wdata,
    output logic [LINE_BITS/8-1:0] wmask,
    input  logic                   read_miss_repair,
    input  logic                   write_miss_repair,
    input  logic [31:0]            missed_addr,
    output logic                   repair_resolved,
    output logic                   mem_req_valid,
    input  logic                   mem_req_ready,
    output logic [31:0]            mem_addr,
    input  logic                   mem_resp_valid,
`ifdef DCACHE_ARB_PERF_EN
    output logic [31:0]            perf_load_miss,
    output logic [31:0]            perf_store_miss,
    output logic [31:0]            perf_collision,
`endif
    input  logic [LINE_BITS-1:0]   mem_resp_data
);

    localparam int LAST     = LOAD_LAT - 1;
    localparam int TAG_BITS = 32 - LINE_OFFSET_BITS;

    arb_state_e state, state_next;

    logic                 pipe_valid [LOAD_LAT];
    logic [31:0]          pipe_addr  [LOAD_LAT];
    logic                 replay_valid;
    logic [31:0]          replay_addr;
    logic                 prefer_store;
    logic                 rd_miss_prev;
    logic [TAG_BITS-1:0]  miss_line;
    logic                 wr_miss_held;
    logic [LINE_BITS-1:0] fetched_line;
    logic [31:0]          pend_data;
    logic [3:0]           pend_be;
    logic [2:0]           pend_off;

    logic                 any_miss, idle_open, collision, cancel;
    logic                 load_issue, replay_issue, store_issue;
    logic [31:0]          issue_addr;
    logic [LINE_BITS-1:0] merge_line, merged;
    logic [31:0]          merge_word;
    logic [3:0]           merge_be;
    logic [2:0]           merge_off;
    logic                 unused_addr_bits;

    assign unused_addr_bits = ^{st_addr[1:0], missed_addr[LINE_OFFSET_BITS-1:0]};
    assign any_miss         = read_miss_repair | write_miss_repair;
    // A freshly raised read miss kills the load currently at the response stage.
    assign cancel           = read_miss_repair & ~rd_miss_prev & pipe_valid[LAST];
    assign load_issue       = ld_valid & ld_ready;
    assign store_issue      = st_valid & st_ready;
    assign issue_addr       = replay_issue ? replay_addr : ld_addr;

    always_comb begin
        state_next   = state;
        ld_ready     = 1'b0;
        st_ready     = 1'b0;
        collision    = 1'b0;
        replay_issue = 1'b0;
        idle_open    = rst && (state == ST_IDLE) && !any_miss;
        case (state)
            ST_IDLE:    if (any_miss) state_next = ST_REQ;
            ST_REQ:     if (mem_req_ready) state_next = ST_WAIT;
            ST_WAIT:    if (mem_resp_valid) state_next = ST_RESOLVE;
            ST_RESOLVE: state_next = ST_IDLE;
            default:    state_next = ST_IDLE;
        endcase
        if (idle_open) begin
            if (replay_valid) begin
                replay_issue = 1'b1;
                st_ready     = st_addr[31:LINE_OFFSET_BITS] != replay_addr[31:LINE_OFFSET_BITS];
            end else begin
                collision = ld_valid && st_valid &&
                            (ld_addr[31:LINE_OFFSET_BITS] == st_addr[31:LINE_OFFSET_BITS]);
                ld_ready  = !collision || !prefer_store;
                st_ready  = !collision || prefer_store;
            end
        end
    end

    always_comb begin
        raddr_valid     = load_issue | replay_issue;
        raddr           = raddr_valid ? issue_addr : '0;
        ld_resp_valid   = pipe_valid[LAST] & ~cancel;
        ld_resp_data    = ld_resp_valid ? rdata : '0;
        mem_req_valid   = (state == ST_REQ);
        mem_addr        = mem_req_valid ? {miss_line, {LINE_OFFSET_BITS{1'b0}}} : '0;
        repair_resolved = (state == ST_RESOLVE);
        merge_line      = '0;
        merge_word      = st_data;
        merge_be        = st_be;
        merge_off       = st_addr[LINE_OFFSET_BITS-1:2];
        waddr_valid     = 1'b0;
        waddr           = '0;
        wmask           = '0;
        // The refill write carries the missed store's bytes, so that store is never re-issued.
        if (repair_resolved) begin
            merge_line  = fetched_line;
            merge_word  = pend_data;
            merge_be    = wr_miss_held ? pend_be : 4'b0000;
            merge_off   = pend_off;
            waddr_valid = 1'b1;
            waddr       = {miss_line, {LINE_OFFSET_BITS{1'b0}}};
            wmask       = '1;
        end else if (store_issue) begin
            waddr_valid = 1'b1;
            waddr       = {st_addr[31:LINE_OFFSET_BITS], {LINE_OFFSET_BITS{1'b0}}};
            wmask       = word_byte_mask(st_be, st_addr[LINE_OFFSET_BITS-1:2]);
        end
        wdata = waddr_valid ? merged : '0;
    end

    dcache_line_merge #(.LINE_BITS(LINE_BITS)) u_merge (
        .line     (merge_line),
        .word     (merge_word),
        .be       (merge_be),
        .word_off (merge_off),
        .merged   (merged)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= ST_IDLE;
            for (int i = 0; i < LOAD_LAT; i++) begin
                pipe_valid[i] <= 1'b0;
                pipe_addr[i]  <= '0;
            end
            replay_valid <= 1'b0;
            replay_addr  <= '0;
            prefer_store <= 1'b0;
            rd_miss_prev <= 1'b0;
            miss_line    <= '0;
            wr_miss_held <= 1'b0;
            fetched_line <= '0;
            pend_data    <= '0;
            pend_be      <= '0;
            pend_off     <= '0;
        end else begin
            state         <= state_next;
            rd_miss_prev  <= read_miss_repair;
            pipe_valid[0] <= load_issue | replay_issue;
            pipe_addr[0]  <= issue_addr;
            for (int i = 1; i < LOAD_LAT; i++) begin
                pipe_valid[i] <= pipe_valid[i-1];
                pipe_addr[i]  <= pipe_addr[i-1];
            end
            if (cancel) begin
                replay_valid <= 1'b1;
                replay_addr  <= pipe_addr[LAST];
            end else if (replay_issue) begin
                replay_valid <= 1'b0;
            end
            if (collision) prefer_store <= !prefer_store;
            if (state == ST_IDLE && any_miss) begin
                miss_line    <= missed_addr[31:LINE_OFFSET_BITS];
                wr_miss_held <= write_miss_repair;
            end
            if (state == ST_WAIT && mem_resp_valid) fetched_line <= mem_resp_data;
            if (store_issue) begin
                pend_data <= st_data;
                pend_be   <= st_be;
                pend_off  <= st_addr[LINE_OFFSET_BITS-1:2];
            end
        end
    end

`ifdef DCACHE_ARB_PERF_EN
    logic wr_miss_prev;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_miss_prev    <= 1'b0;
            perf_load_miss  <= '0;
            perf_store_miss <= '0;
            perf_collision  <= '0;
        end else begin
            wr_miss_prev <= write_miss_repair;
            if (read_miss_repair && !rd_miss_prev)  perf_load_miss  <= perf_load_miss + 32'd1;
            if (write_miss_repair && !wr_miss_prev) perf_store_miss <= perf_store_miss + 32'd1;
            if (collision)                          perf_collision  <= perf_collision + 32'd1;
        end
    end
`endif

endmodule

// File: doc/dcache_arbiter.md
DCACHE_ARBITER -- requirements
Module: dcache_arbiter

Interface
REQ-001 Parameter: LOAD_LAT, 2, cycles from cache read issue to rdata valid.
REQ-002 Parameter: LINE_BITS, 256, cache line width; byte mask width is LINE_BITS/8.
REQ-003 Ports, clock and reset first:
- clk  in  1  single clock.
- rst  in  1  asynchronous, active-low reset.
- ld_valid / ld_ready  in / out  1 / 1  load request handshake.
- ld_addr  in  32  load byte address.
- ld_resp_valid / ld_resp_data  out / out  1 / 32  load result.
- st_valid / st_ready  in / out  1 / 1  store request handshake.
- st_addr  in  32  store byte address.
- st_data / st_be  in / in  32 / 4  store word and byte enables.
- raddr_valid / raddr  out / out  1 / 32  cache read port.
- rdata  in  32  cache read word.
- waddr_valid / waddr  out / out  1 / 32  cache write port.
- wdata / wmask  out / out  LINE_BITS / LINE_BITS/8  cache write line and byte mask.
- read_miss_repair / write_miss_repair  in / in  1 / 1  cache miss flags.
- missed_addr  in  32  missing address.
- repair_resolved  out  1  refill line presented this cycle.
- mem_req_valid / mem_req_ready / mem_addr  out / in / out  1 / 1 / 32  line fetch request.
- mem_resp_valid / mem_resp_data  in / in  1 / LINE_BITS  line fetch return.

Function
REQ-004 Line address: addr[31:5]. Word offset: addr[4:2]. Store data SHALL be placed at byte lane 4*addr[4:2], with wmask bits set from st_be.
REQ-005 FSM states and transitions:
- IDLE -> REQ when either miss flag is 1.
- REQ -> WAIT on mem_req_valid & mem_req_ready.
- WAIT -> RESOLVE on mem_resp_valid.
- RESOLVE -> IDLE after exactly 1 cycle.
REQ-006 In IDLE with both miss flags 0:
- ld_ready=1 and st_ready=1.
- Accepted requests drive raddr_valid/waddr_valid in the same cycle (combinational pass-through).
REQ-007 Same-line collision (load and store both valid, equal line addresses):
- Grant only one requester; deny the other its ready.
- Alternate the winner using a last-grant bit; after reset the load wins first.
REQ-008 Different lines: both load and store SHALL be granted in the same cycle.
REQ-009 Load in-flight tracking:
- A LOAD_LAT-deep valid/offset shift register SHALL track issued loads.
- ld_resp_valid asserts LOAD_LAT cycles after issue with ld_resp_data=rdata, unless cancelled.
REQ-010 Miss cancellation:
- When read_miss_repair rises, the in-flight load at the tag-check stage SHALL be cancelled (no ld_resp_valid).
- Its address SHALL be captured in a replay register.
REQ-011 In REQ, mem_addr = {missed_addr[31:5],5'b0}, held stable with mem_req_valid=1 until mem_req_ready.
REQ-012 In WAIT, the line is captured on mem_resp_valid. mem_resp_valid outside WAIT SHALL be ignored.
REQ-013 In RESOLVE:
- repair_resolved=1; waddr=missed line address; wmask=all ones.
- wdata=fetched line, with the pending store's enabled bytes merged in if write_miss_repair was set.
- The pending store SHALL NOT be re-issued.
REQ-014 First IDLE cycle after RESOLVE: a pending replay load SHALL issue before any new load, and ld_ready=0 that cycle.
REQ-015 Both miss flags set at once SHALL be served by one fetch of missed_addr.
REQ-016 ld_ready=st_ready=0 in every state other than IDLE.

Reset
REQ-017 rst low SHALL immediately do all of the following:
- Force state IDLE.
- Clear the shift register, replay register, last-grant bit (to load) and every output.
- Drop any in-progress fetch.
REQ-018 A mem_resp_valid arriving after reset release for a dropped fetch SHALL be ignored.

Configuration
REQ-019 Macro DCACHE_ARB_PERF_EN:
- Defined: add outputs perf_load_miss, perf_store_miss, perf_collision (32-bit each, wrapping), each incrementing by 1 per event, reset to 0.
- Undefined: these ports and counters are absent.

Structure
REQ-020 CORE_PKG SHALL hold the FSM state enum, the LINE_OFFSET_BITS=5 constant, and the line-merge byte-mask helper function.
REQ-021 One sub-module, dcache_line_merge, SHALL be combinational: line + word + byte enables + offset -> merged line.

Verification
REQ-022 The bench SHALL cover:
- Load 0x100 with hit: ld_resp_valid exactly 2 cycles later, data = rdata.
- Load 0x100 and store 0x104 in the same cycle: first grant is load only; repeat; second grant is store only.
- Read miss at 0x2040: mem_addr=0x2040; resolve with wmask=all ones; replayed load returns data once.
- Write miss at 0x3008, st_be=4'b0011, data 0xAABB: RESOLVE wdata bytes 8-9 = BB,AA; remaining bytes from mem.
- rst low during WAIT: outputs cleared; late mem_resp_valid ignored; next hit serviced normally.
